// File: rtl/mm_bus_arb.sv
// mm_bus_arb: shares the external memory-mapped bus between the CPU port and
// a secondary (DMA/debug) master. The CPU is stalled until its access ends,
// the DMA is forced in after STARVE_LIMIT back-to-back CPU wins, and hung
// peripheral accesses are terminated after TIMEOUT wait cycles.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | bus strobes low; arbitration between cpu_req and dma_req
// ST_CPU_XFER | captured CPU access driven on the bus, waiting for bus_rdy
// ST_DMA_XFER | captured DMA access driven on the bus, waiting for bus_rdy

module mm_bus_arb #(
    parameter int          STARVE_LIMIT = 4,
    parameter int          TIMEOUT      = 15,
    parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_done,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_re,
    output logic        bus_we,
    input  logic [15:0] bus_rdata,
    input  logic        bus_rdy,
    output logic        bus_err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CPU_XFER = 2'd1;
    localparam logic [1:0] ST_DMA_XFER = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic [7:0] wait_cnt;

    logic cpu_req;
    logic in_idle;
    logic in_xfer;
    logic wait_expired;
    logic xfer_end;
    logic timed_out;
    logic dma_grant;
    logic cpu_grant;
    logic cpu_end;
    logic dma_end;

    // Request decode, arbitration and completion detection.
    always_comb begin
        cpu_req      = cpu_re | cpu_we;
        in_idle      = (state == ST_IDLE);
        in_xfer      = (state == ST_CPU_XFER) || (state == ST_DMA_XFER);
        wait_expired = (wait_cnt == WAIT_MAX);
        xfer_end     = in_xfer & (bus_rdy | wait_expired);
        timed_out    = in_xfer & ~bus_rdy & wait_expired;
        dma_grant    = in_idle & dma_req & ((starve_cnt == STARVE_MAX) | ~cpu_req);
        cpu_grant    = in_idle & ~dma_grant & cpu_req;
        cpu_end      = (state == ST_CPU_XFER) & xfer_end;
        dma_end      = (state == ST_DMA_XFER) & xfer_end;
    end

    // CPU-facing outputs are combinational so the CPU samples read data on
    // the same edge where its stall releases.
    always_comb begin
        bus_err   = timed_out;
        cpu_stall = cpu_req & ~cpu_end;
        cpu_rdata = 16'h0000;
        if (cpu_end && bus_re) begin
            cpu_rdata = bus_rdy ? bus_rdata : ERR_DATA;
        end
    end

    // Bus ownership state machine; every transfer returns through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dma_grant) begin
                        state <= ST_DMA_XFER;
                    end else if (cpu_grant) begin
                        state <= ST_CPU_XFER;
                    end
                end
                ST_CPU_XFER, ST_DMA_XFER: begin
                    if (xfer_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Wait timer: counts transfer cycles without bus_rdy, idle resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (!in_xfer || xfer_end) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Starvation counter: CPU wins while the DMA waits, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (dma_grant) begin
            starve_cnt <= 4'd0;
        end else if (cpu_grant) begin
            if (!dma_req) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Capture the winner's access on the grant edge and hold it until the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
        end else if (dma_grant) begin
            bus_addr  <= dma_addr;
            bus_wdata <= dma_wdata;
            bus_re    <= ~dma_we;
            bus_we    <= dma_we;
        end else if (cpu_grant) begin
            bus_addr  <= cpu_addr;
            bus_wdata <= cpu_wdata;
            // Simultaneous read and write requests resolve to a write.
            bus_re    <= cpu_re & ~cpu_we;
            bus_we    <= cpu_we;
        end else if (xfer_end) begin
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
        end
    end

    // DMA completion pulse and read data, registered one cycle after the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_done  <= 1'b0;
            dma_rdata <= 16'h0000;
        end else begin
            dma_done <= dma_end;
            if (dma_end && bus_re) begin
                dma_rdata <= bus_rdy ? bus_rdata : ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_mm_bus_arb.sv
// Randomized bench for mm_bus_arb against a transaction-level reference model:
// each granted access gets a planned peripheral delay, and the model predicts
// strobes, stall, read data, error and DMA completion from that plan.

module tb_mm_bus_arb;

    localparam int          STARVE_LIMIT = 4;
    localparam int          TIMEOUT      = 15;
    localparam logic [15:0] ERR_DATA     = 16'hDEAD;

    logic        clk;
    logic        rst_n;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] dma_rdata;
    logic        dma_done;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_re;
    logic        bus_we;
    logic [15:0] bus_rdata;
    logic        bus_rdy;
    logic        bus_err;

    mm_bus_arb #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT),
        .ERR_DATA    (ERR_DATA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_re   (cpu_re),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata),
        .dma_done (dma_done),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_re   (bus_re),
        .bus_we   (bus_we),
        .bus_rdata(bus_rdata),
        .bus_rdy  (bus_rdy),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: current transaction and its planned peripheral delay.
    bit          m_busy;
    bit          m_is_dma;
    bit          m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    int          m_elapsed;
    int          m_delay;
    int          m_cpu_wins;
    bit          m_done_due;
    logic [15:0] m_dma_rdata;
    bit          m_cpu_fin;

    // Stimulus knobs (percent probabilities, max normal delay, starvation check).
    int k_cpu;
    int k_dma;
    int k_to;
    int k_maxd;
    bit k_strict;

    // Observer of DUT bus starts for the starvation property.
    bit prev_act;
    bit seen_dma;
    int cpu_run_obs;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 99);
        if (r < k_to) return TIMEOUT + 5;
        if (k_to > 0 && r >= 95) return TIMEOUT;
        return $urandom_range(0, k_maxd);
    endfunction

    task automatic model_reset();
        m_busy      = 1'b0;
        m_is_dma    = 1'b0;
        m_we        = 1'b0;
        m_elapsed   = 0;
        m_delay     = 0;
        m_cpu_wins  = 0;
        m_done_due  = 1'b0;
        m_dma_rdata = 16'h0000;
        m_cpu_fin   = 1'b0;
    endtask

    // Called mid-cycle: compare DUT against model, then advance model one edge.
    task automatic model_cycle();
        bit          req_c;
        bit          done_now;
        bit          to_now;
        bit          act;
        logic [15:0] exp_rd;
        req_c     = cpu_re | cpu_we;
        m_cpu_fin = 1'b0;
        done_now  = 1'b0;
        to_now    = 1'b0;

        act = bus_re | bus_we;
        if (act && !prev_act) begin
            if (bus_addr[15]) begin
                if (k_strict && seen_dma) check_val("starve_run", 16'(cpu_run_obs), 16'(STARVE_LIMIT));
                cpu_run_obs = 0;
                seen_dma    = 1'b1;
            end else begin
                cpu_run_obs++;
            end
        end
        prev_act = act;

        if (m_busy) begin
            done_now = bus_rdy || (m_elapsed == TIMEOUT);
            to_now   = !bus_rdy && (m_elapsed == TIMEOUT);
            check_val("bus_re", 16'(bus_re), 16'(!m_we));
            check_val("bus_we", 16'(bus_we), 16'(m_we));
            check_val("bus_addr", bus_addr, m_addr);
            if (m_we) check_val("bus_wdata", bus_wdata, m_wdata);
            check_val("bus_err", 16'(bus_err), 16'(to_now));
            exp_rd = 16'h0000;
            if (!m_is_dma && done_now && !m_we) exp_rd = bus_rdy ? bus_rdata : ERR_DATA;
            check_val("cpu_rdata", cpu_rdata, exp_rd);
            check_val("cpu_stall", 16'(cpu_stall), 16'(req_c && !(!m_is_dma && done_now)));
        end else begin
            check_val("idle_re", 16'(bus_re), 16'h0);
            check_val("idle_we", 16'(bus_we), 16'h0);
            check_val("idle_err", 16'(bus_err), 16'h0);
            check_val("idle_rdata", cpu_rdata, 16'h0000);
            check_val("idle_stall", 16'(cpu_stall), 16'(req_c));
        end
        check_val("dma_done", 16'(dma_done), 16'(m_done_due));
        check_val("dma_rdata", dma_rdata, m_dma_rdata);

        m_done_due = m_busy && m_is_dma && done_now;
        if (m_done_due && !m_we) m_dma_rdata = bus_rdy ? bus_rdata : ERR_DATA;

        if (m_busy) begin
            if (done_now) begin
                m_busy    = 1'b0;
                m_cpu_fin = !m_is_dma;
            end else begin
                m_elapsed++;
            end
        end else if (dma_req && (m_cpu_wins >= STARVE_LIMIT || !req_c)) begin
            m_busy     = 1'b1;
            m_is_dma   = 1'b1;
            m_we       = dma_we;
            m_addr     = dma_addr;
            m_wdata    = dma_wdata;
            m_elapsed  = 0;
            m_delay    = pick_delay();
            m_cpu_wins = 0;
        end else if (req_c) begin
            m_busy     = 1'b1;
            m_is_dma   = 1'b0;
            m_we       = cpu_we;
            m_addr     = cpu_addr;
            m_wdata    = cpu_wdata;
            m_elapsed  = 0;
            m_delay    = pick_delay();
            m_cpu_wins = dma_req ? ((m_cpu_wins < STARVE_LIMIT) ? m_cpu_wins + 1 : m_cpu_wins) : 0;
        end
    endtask

    // Called just after an edge: requesters honour the hold-until-done protocol.
    task automatic drive();
        int r;
        if (m_cpu_fin || !(cpu_re || cpu_we)) begin
            if ($urandom_range(0, 99) < k_cpu) begin
                r         = $urandom_range(0, 3);
                cpu_re    = (r != 1);
                cpu_we    = (r == 1) || (r == 2);
                cpu_addr  = {1'b0, 15'($urandom)};
                cpu_wdata = 16'($urandom);
            end else begin
                cpu_re = 1'b0;
                cpu_we = 1'b0;
            end
        end
        if (m_done_due || !dma_req) begin
            if ($urandom_range(0, 99) < k_dma) begin
                dma_req   = 1'b1;
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = {1'b1, 15'($urandom)};
                dma_wdata = 16'($urandom);
            end else begin
                dma_req = 1'b0;
            end
        end
        bus_rdy   = m_busy ? (m_elapsed == m_delay) : 1'($urandom_range(0, 1));
        bus_rdata = 16'($urandom);
    endtask

    task automatic one_cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_phase(input int cycles, input int p_cpu, input int p_dma,
                             input int p_to, input int maxd, input bit strict);
        k_cpu       = p_cpu;
        k_dma       = p_dma;
        k_to        = p_to;
        k_maxd      = maxd;
        k_strict    = strict;
        seen_dma    = 1'b0;
        cpu_run_obs = 0;
        for (int i = 0; i < cycles; i++) one_cycle();
    endtask

    initial begin
        bit found;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 16'h0000;
        dma_wdata = 16'h0000;
        bus_rdata = 16'h0000;
        bus_rdy   = 1'b0;
        prev_act  = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check_val("rst_bus_addr", bus_addr, 16'h0000);
        check_val("rst_bus_wdata", bus_wdata, 16'h0000);
        check_val("rst_bus_re", 16'(bus_re), 16'h0);
        check_val("rst_bus_we", 16'(bus_we), 16'h0);
        check_val("rst_bus_err", 16'(bus_err), 16'h0);
        check_val("rst_dma_done", 16'(dma_done), 16'h0);
        check_val("rst_dma_rdata", dma_rdata, 16'h0000);
        check_val("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check_val("rst_stall_idle", 16'(cpu_stall), 16'h0);
        cpu_re = 1'b1;
        #1 check_val("rst_stall_req", 16'(cpu_stall), 16'h1);
        cpu_re = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_phase(200, 60, 0, 0, 3, 1'b0);
        run_phase(200, 100, 100, 0, 0, 1'b1);
        run_phase(80, 0, 100, 100, 0, 1'b0);
        run_phase(2000, 50, 40, 8, 4, 1'b0);

        // Reset in the first cycle of a CPU transfer that would otherwise hang.
        k_cpu = 100;
        k_dma = 0;
        k_to  = 100;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            one_cycle();
            if (m_busy && !m_is_dma) found = 1'b1;
        end
        check_val("rst_find_xfer", 16'(found), 16'h1);
        if (found) begin
            #1 rst_n = 1'b0;
            #1;
            check_val("mid_rst_re", 16'(bus_re), 16'h0);
            check_val("mid_rst_we", 16'(bus_we), 16'h0);
            check_val("mid_rst_err", 16'(bus_err), 16'h0);
            check_val("mid_rst_stall", 16'(cpu_stall), 16'h1);
            model_reset();
            @(posedge clk);
            #2;
            check_val("mid_rst_done", 16'(dma_done), 16'h0);
            rst_n = 1'b1;
        end
        run_phase(300, 50, 40, 8, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_bus_arb.md
# mm_bus_arb

Arbiter and sequencer for the external memory-mapped bus. It shares one downstream peripheral bus between two requesters: the CPU's external-access port and a secondary master (DMA/debug). The CPU port is its `mm_re`/`mm_we`/`addr`/`wdata`/`rdata` path; the secondary master is `dma_*`. The block stalls the CPU pipeline until its access completes, prevents starvation of the secondary master, and terminates hung peripheral accesses with a timeout.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive CPU grants allowed while `dma_req` is pending before the DMA is forced in (legal 1..15).
- TIMEOUT, 15, cycles in a transfer state without `bus_rdy` before forced completion (legal 1..255).
- ERR_DATA, 16'hDEAD, read data returned on a timed-out read.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cpu_re  in  1  CPU external read request; held until `cpu_stall` falls.
- cpu_we  in  1  CPU external write request; held until `cpu_stall` falls.
- cpu_addr  in  16  CPU access address.
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  read data to the CPU.
- cpu_stall  out  1  freeze the CPU pipeline (combinational).
- dma_req  in  1  DMA request level; held until `dma_done`.
- dma_we  in  1  DMA direction: 1 = write, 0 = read.
- dma_addr  in  16  DMA address.
- dma_wdata  in  16  DMA write data.
- dma_rdata  out  16  DMA read data (registered).
- dma_done  out  1  one-cycle DMA completion pulse.
- bus_addr  out  16  downstream address.
- bus_wdata  out  16  downstream write data.
- bus_re  out  1  downstream read strobe.
- bus_we  out  1  downstream write strobe.
- bus_rdata  in  16  downstream read data; valid when `bus_rdy` is high.
- bus_rdy  in  1  downstream completion.
- bus_err  out  1  one-cycle pulse on timeout.

## Operation
- Three states:
  - IDLE: bus strobes are 0.
  - CPU_XFER: drives the captured CPU request on the bus.
  - DMA_XFER: drives the captured DMA request on the bus.
- Request signals:
  - cpu_req = `cpu_re` | `cpu_we`.
  - `cpu_re` and `cpu_we` both high is a write; `bus_re` stays 0.
- Arbitration (in IDLE only):
  - `dma_req` & (starve_cnt == STARVE_LIMIT | ~cpu_req) → DMA_XFER.
  - Else cpu_req → CPU_XFER.
  - Else stay in IDLE.
- Capture: address, data and direction of the winner are registered into `bus_*` on the grant edge and held constant for the whole transfer.
- starve_cnt (4-bit):
  - +1 on each CPU grant while `dma_req` is high (saturating at STARVE_LIMIT).
  - Cleared on a DMA grant, or on any grant while `dma_req` is low.
- Completion occurs in a transfer-state cycle with `bus_rdy` = 1, or with wait_cnt == TIMEOUT.
  - On the next edge the state returns to IDLE, the strobes drop and wait_cnt clears.
  - IDLE always lasts at least one cycle between transfers.
- wait_cnt (8-bit): +1 each transfer-state cycle without `bus_rdy`; cleared in IDLE.
- Timeout completion:
  - `bus_err` pulses in the completion cycle.
  - A read returns ERR_DATA.
  - A write is dropped; the peripheral side effect is undefined.
- cpu_stall = cpu_req & ~(state == CPU_XFER & completion). Combinational, so it also applies in IDLE and while the DMA owns the bus.
- cpu_rdata = `bus_rdy` ? `bus_rdata` : ERR_DATA during a CPU read completion; otherwise 16'h0000. It is combinational so the CPU samples it on the edge where the stall releases.
- DMA completion: `dma_done` = 1 for the cycle after completion, with `dma_rdata` registered (`bus_rdata`, or ERR_DATA on timeout). `dma_rdata` holds until the next DMA read completion.
- `bus_rdy` outside a transfer state is ignored.

## Timing
- Reset values:
  - state = IDLE; all counters = 0.
  - `bus_addr`, `bus_wdata`, `bus_re`, `bus_we`, `bus_err`, `dma_done` = 0.
  - `dma_rdata` = 16'h0000.
  - `cpu_rdata` = 0; `cpu_stall` follows its combinational equation.
- Reset asserted mid-transfer: the transfer is abandoned immediately and no `dma_done` or `bus_err` is produced.
- Minimum CPU access: request in cycle 0 (IDLE, stall = 1); strobes in cycle 1; `bus_rdy` in cycle 1 → stall = 0 in cycle 1. Two cycles total.
- Minimum DMA access: request in cycle 0; strobes in cycle 1; `bus_rdy` in cycle 1; `dma_done` in cycle 2.
- Peak throughput: one transfer per 2 cycles.
- Timeout: completion in the (TIMEOUT+1)-th transfer cycle.
- A new `dma_req` may be asserted in the `dma_done` cycle and is arbitrated in that IDLE cycle.

## Test plan
- CPU read to 16'hE000, `bus_rdy` in its first cycle with `bus_rdata` = 16'h1234 → stall high 1 cycle; `cpu_rdata` = 16'h1234 in the release cycle; `bus_re` high exactly 1 cycle.
- CPU write with `cpu_wdata` = 16'hA5A5, `bus_rdy` delayed 3 cycles → `bus_we`/`bus_wdata` stable 4 cycles; stall high 4 cycles; `bus_err` = 0.
- Continuous CPU requests plus `dma_req` held, STARVE_LIMIT = 4 → exactly 4 CPU transfers, then 1 DMA transfer with `dma_done` pulse; CPU stalled during it; starve_cnt back to 0.
- `dma_req` and cpu_req both rising in the same IDLE cycle with starve_cnt = 0 → CPU granted first.
- DMA read, `bus_rdy` never asserted, TIMEOUT = 15 → `bus_err` pulse on transfer cycle 16; `dma_rdata` = 16'hDEAD; state returns to IDLE.
- `rst_n` dropped during CPU_XFER → strobes 0 immediately; after release, a held request restarts from IDLE with 2-cycle latency.
